// File: rtl/fetch_pc_unit_if.sv
// Fetch PC unit bus: redirect/trap/stall/prediction requests into the unit, fetch group out.
// Parameters must match the fetch_pc_unit instance that uses it.
interface fetch_pc_unit_if #(
   parameter int XLEN        = 32,
   parameter int FETCH_WIDTH = 2
);
   localparam int LANE_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

   logic                   StallF;
   logic                   TrapValid;
   logic [XLEN-1:0]        TrapTarget;
   logic                   RedirectE;
   logic [XLEN-1:0]        RedirectTargetE;
   logic                   PredTakenF;
   logic [LANE_W-1:0]      PredLaneF;
   logic [XLEN-1:0]        PredTargetF;
   logic [XLEN-1:0]        PCF;
   logic                   FetchValidF;
   logic [FETCH_WIDTH-1:0] LaneValidF;
   logic                   MisalignF;

   modport master (
      output StallF, TrapValid, TrapTarget, RedirectE, RedirectTargetE,
             PredTakenF, PredLaneF, PredTargetF,
      input  PCF, FetchValidF, LaneValidF, MisalignF
   );

   modport slave (
      input  StallF, TrapValid, TrapTarget, RedirectE, RedirectTargetE,
             PredTakenF, PredLaneF, PredTargetF,
      output PCF, FetchValidF, LaneValidF, MisalignF
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: one aligned group of FETCH_WIDTH instructions per cycle, next PC on the next edge.
// StallF holds PC and state; trap and execute redirect override the stall.
module fetch_pc_unit #(
   parameter int              XLEN         = 32,
   parameter int              FETCH_WIDTH  = 2,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000)
) (
   input  logic                 CLK,
   input  logic                 reset,
   fetch_pc_unit_if.slave       fif
);
   localparam int              G          = FETCH_WIDTH * 4;
   localparam logic [XLEN-1:0] GROUP_MASK = XLEN'(G - 1);
   localparam logic [XLEN-1:0] LANE_MASK  = XLEN'(FETCH_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] base;
   int              off_i;
   logic            pred_live;
   logic            run;
   logic [FETCH_WIDTH-1:0] lane_vld;

   always_ff @(posedge CLK) begin
      if (reset) begin
         pc_q    <= RESET_VECTOR;
         state_q <= ST_BOOT;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

   always_comb begin
      base      = pc_q & ~GROUP_MASK;
      off_i     = int'((pc_q >> 2) & LANE_MASK);
      run       = (state_q == ST_RUN);
      // A prediction for a lane before the entry offset is stale and ignored.
      pred_live = fif.PredTakenF && (int'(fif.PredLaneF) >= off_i);

      pc_d    = pc_q;
      state_d = state_q;
      if (fif.TrapValid) begin
         pc_d    = {fif.TrapTarget[XLEN-1:2], 2'b00};
         state_d = ST_RUN;
      end else if (fif.RedirectE && (state_q != ST_FAULT)) begin
         pc_d    = fif.RedirectTargetE;
         state_d = (fif.RedirectTargetE[1:0] != 2'b00) ? ST_FAULT : ST_RUN;
      end else if (!fif.StallF) begin
         case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  pc_d    = pred_live ? fif.PredTargetF : base + XLEN'(G);
            default: state_d = state_q;
         endcase
      end

      // The mask qualifies the current group with the predictor's same-cycle answer for it.
      lane_vld = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         lane_vld[i] = run && (i >= off_i) &&
                       (!pred_live || (i <= int'(fif.PredLaneF)));
      end
   end

   assign fif.PCF         = pc_q;
   assign fif.FetchValidF = run;
   assign fif.MisalignF   = (state_q == ST_FAULT);
   assign fif.LaneValidF  = lane_vld;

endmodule
